// File: rtl/vec_product_sched.sv
// Mat-vec sequencer for vec_product: issues chunk reads, stages operands, accumulates rows, queues results.
// Latency: issue at t, operands valid t+2, row result at o_res_valid from t+3; 1 chunk/cycle when unstalled.
// Backpressure: a row's last chunk issues only while queued+in-flight results < 2, so the 2-entry queue never overflows.
module vec_product_sched #(
    parameter int DATA_W = 4,
    parameter int VS     = 64,
    parameter int RES_W  = 14,
    parameter int ACC_W  = 24,
    parameter int ROW_W  = 8,
    parameter int CHK_W  = 6
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic [ROW_W-1:0]       i_rows_m1,
    input  logic [CHK_W-1:0]       i_chunks_m1,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_rd_en,
    output logic [ROW_W+CHK_W-1:0] o_w_addr,
    output logic [CHK_W-1:0]       o_x_addr,
    input  logic [DATA_W*VS-1:0]   i_w_data,
    input  logic [DATA_W*VS-1:0]   i_x_data,
    output logic [DATA_W*VS-1:0]   o_vp_a,
    output logic [DATA_W*VS-1:0]   o_vp_b,
    input  logic [RES_W-1:0]       i_vp_product,
    output logic                   o_res_valid,
    input  logic                   i_res_ready,
    output logic [ACC_W-1:0]       o_res_data,
    output logic [ROW_W-1:0]       o_res_row
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    state_t state, state_nxt;

    logic [ROW_W-1:0]       rows_m1, row_cnt;
    logic [CHK_W-1:0]       chunks_m1, chk_cnt;
    logic [ROW_W+CHK_W-1:0] w_addr;
    logic                   p0_vld, p0_first, p0_last;
    logic [ROW_W-1:0]       p0_row;
    logic                   p1_vld, p1_first, p1_last;
    logic [ROW_W-1:0]       p1_row;
    logic [ACC_W-1:0]       acc, acc_nxt, prod_ext;
    logic [ACC_W-1:0]       q_data [2];
    logic [ROW_W-1:0]       q_row  [2];
    logic                   q_wp, q_rp;
    logic [1:0]             q_cnt;
    logic [2:0]             credit_used;
    logic                   chk_last, row_last, issue_ok, pipe_empty, push, pop;

    assign chk_last   = (chk_cnt == chunks_m1);
    assign row_last   = (row_cnt == rows_m1);
    // results that will occupy the queue: already queued plus last-chunk reads still in the pipe
    assign credit_used = {1'b0, q_cnt} + {2'b0, p0_vld & p0_last} + {2'b0, p1_vld & p1_last};
    assign issue_ok   = (credit_used < 3'd2);
    assign pipe_empty = !p0_vld && !p1_vld;
    assign push       = p1_vld && p1_last;
    assign pop        = o_res_valid && i_res_ready;
    assign prod_ext   = ACC_W'($signed(i_vp_product));
    assign acc_nxt    = p1_first ? prod_ext : acc + prod_ext;

    assign o_w_addr    = w_addr;
    assign o_x_addr    = chk_cnt;
    assign o_res_valid = (q_cnt != 2'd0);
    assign o_res_data  = q_data[q_rp];
    assign o_res_row   = q_row[q_rp];

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        o_busy    = 1'b1;
        o_done    = 1'b0;
        o_rd_en   = 1'b0;
        case (state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) state_nxt = S_RUN;
            end
            S_RUN: begin
                o_rd_en = !chk_last || issue_ok;
                if (o_rd_en && chk_last && row_last) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                // leave as soon as the final result is being popped, so o_done follows the pop directly
                if (pipe_empty && (q_cnt == 2'd0 || (q_cnt == 2'd1 && pop))) state_nxt = S_DONE;
            end
            S_DONE: begin
                o_done    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rows_m1   <= '0;
            chunks_m1 <= '0;
            row_cnt   <= '0;
            chk_cnt   <= '0;
            w_addr    <= '0;
        end else if (state == S_IDLE && i_start) begin
            rows_m1   <= i_rows_m1;
            chunks_m1 <= i_chunks_m1;
            row_cnt   <= '0;
            chk_cnt   <= '0;
            w_addr    <= '0;
        end else if (o_rd_en) begin
            w_addr <= w_addr + 1'b1;
            if (chk_last) begin
                chk_cnt <= '0;
                row_cnt <= row_cnt + 1'b1;
            end else begin
                chk_cnt <= chk_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            p0_vld   <= 1'b0;
            p0_first <= 1'b0;
            p0_last  <= 1'b0;
            p0_row   <= '0;
            p1_vld   <= 1'b0;
            p1_first <= 1'b0;
            p1_last  <= 1'b0;
            p1_row   <= '0;
            o_vp_a   <= '0;
            o_vp_b   <= '0;
            acc      <= '0;
        end else begin
            p0_vld   <= o_rd_en;
            p0_first <= (chk_cnt == '0);
            p0_last  <= chk_last;
            p0_row   <= row_cnt;
            p1_vld   <= p0_vld;
            if (p0_vld) begin
                o_vp_a   <= i_w_data;
                o_vp_b   <= i_x_data;
                p1_first <= p0_first;
                p1_last  <= p0_last;
                p1_row   <= p0_row;
            end
            if (p1_vld) acc <= acc_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            q_data[0] <= '0;
            q_data[1] <= '0;
            q_row[0]  <= '0;
            q_row[1]  <= '0;
            q_wp      <= 1'b0;
            q_rp      <= 1'b0;
            q_cnt     <= 2'd0;
        end else begin
            if (push) begin
                q_data[q_wp] <= acc_nxt;
                q_row[q_wp]  <= p1_row;
                q_wp         <= ~q_wp;
            end
            if (pop) q_rp <= ~q_rp;
            if (push && !pop)      q_cnt <= q_cnt + 2'd1;
            else if (pop && !push) q_cnt <= q_cnt - 2'd1;
        end
    end
endmodule

// File: tb/tb_vec_product_sched.sv
// Directed bench: buffer and vec_product models around two schedulers (ACC_W 24 and 16) sharing all inputs.
module tb_vec_product_sched;
    localparam int VS = 64;

    logic         i_clk, i_rst, i_start, i_res_ready;
    logic [7:0]   i_rows_m1;
    logic [5:0]   i_chunks_m1;
    logic [255:0] i_w_data, i_x_data;
    logic         o_busy, o_done, o_rd_en, o_res_valid;
    logic [13:0]  o_w_addr, vp_prod, vp_prod16;
    logic [5:0]   o_x_addr;
    logic [255:0] o_vp_a, o_vp_b;
    logic [23:0]  o_res_data;
    logic [7:0]   o_res_row;
    logic         busy16, done16, rd16, valid16;
    logic [13:0]  waddr16;
    logic [5:0]   xaddr16;
    logic [255:0] vpa16, vpb16;
    logic [15:0]  data16;
    logic [7:0]   row16;

    vec_product_sched dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_rows_m1(i_rows_m1),
        .i_chunks_m1(i_chunks_m1), .o_busy(o_busy), .o_done(o_done), .o_rd_en(o_rd_en),
        .o_w_addr(o_w_addr), .o_x_addr(o_x_addr), .i_w_data(i_w_data), .i_x_data(i_x_data),
        .o_vp_a(o_vp_a), .o_vp_b(o_vp_b), .i_vp_product(vp_prod), .o_res_valid(o_res_valid),
        .i_res_ready(i_res_ready), .o_res_data(o_res_data), .o_res_row(o_res_row));

    vec_product_sched #(.ACC_W(16)) dut16 (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_rows_m1(i_rows_m1),
        .i_chunks_m1(i_chunks_m1), .o_busy(busy16), .o_done(done16), .o_rd_en(rd16),
        .o_w_addr(waddr16), .o_x_addr(xaddr16), .i_w_data(i_w_data), .i_x_data(i_x_data),
        .o_vp_a(vpa16), .o_vp_b(vpb16), .i_vp_product(vp_prod16), .o_res_valid(valid16),
        .i_res_ready(i_res_ready), .o_res_data(data16), .o_res_row(row16));

    function automatic logic [13:0] dot(input logic [255:0] a, input logic [255:0] b);
        int s;
        s = 0;
        for (int i = 0; i < VS; i++) s += int'($signed(a[i*4 +: 4])) * int'($signed(b[i*4 +: 4]));
        return s[13:0];
    endfunction

    assign vp_prod   = dot(o_vp_a, o_vp_b);
    assign vp_prod16 = dot(vpa16, vpb16);

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // buffer model: weight element = w_base + w_inc*addr, activation element = x_el, one cycle after o_rd_en
    logic [3:0]  w_base, w_inc, x_el, w_el;
    logic        rd_pend;
    logic [13:0] addr_pend;
    always @(negedge i_clk) begin
        rd_pend   = o_rd_en;
        addr_pend = o_w_addr;
    end
    always @(posedge i_clk) begin
        #1;
        if (rd_pend) begin
            w_el     = 4'(w_base + w_inc * addr_pend[3:0]);
            i_w_data = {VS{w_el}};
            i_x_data = {VS{x_el}};
        end
    end

    int n_cmp, n_bad;
    logic [23:0] got_data[$];
    logic [7:0]  got_row[$];
    logic [15:0] got16[$];
    logic [13:0] rd_addr[$];
    int          done_cnt, done_cyc, last_vld_cyc, rd_low, busy_end;
    logic        hold_vld;
    logic [23:0] hold_data;
    logic [7:0]  hold_row;

    task automatic start_job(input logic [7:0] rows_m1, input logic [5:0] chunks_m1);
        i_rows_m1   = rows_m1;
        i_chunks_m1 = chunks_m1;
        i_start     = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    // cycle 0 = first RUN cycle; records transfers, reads and o_done, runs 4 cycles past the first o_done
    task automatic collect(input int budget, input int ready_low, input int pulse_at);
        int tail;
        got_data.delete(); got_row.delete(); got16.delete(); rd_addr.delete();
        done_cnt = 0; done_cyc = -1; last_vld_cyc = -1; rd_low = 0;
        hold_vld = 1'b0; hold_data = '0; hold_row = '0;
        tail = -1;
        for (int c = 0; c < budget && tail != 0; c++) begin
            i_res_ready = (c >= ready_low);
            i_start     = (c == pulse_at);
            if (c == pulse_at) begin
                i_rows_m1   = 8'd7;
                i_chunks_m1 = 6'd5;
            end
            #1;
            if (o_rd_en) begin
                rd_addr.push_back(o_w_addr);
                if (c < ready_low) rd_low++;
            end
            if (o_res_valid) last_vld_cyc = c;
            if (o_res_valid && i_res_ready) begin
                got_data.push_back(o_res_data);
                got_row.push_back(o_res_row);
            end
            if (valid16 && i_res_ready) got16.push_back(data16);
            if (c == ready_low - 1) begin
                hold_vld  = o_res_valid;
                hold_data = o_res_data;
                hold_row  = o_res_row;
            end
            if (o_done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    tail = 5;
                end
            end
            if (tail > 0) tail--;
            @(negedge i_clk);
        end
        i_start  = 1'b0;
        busy_end = int'(o_busy);
    endtask

    task automatic test_reset;
        i_rst = 1'b1; i_start = 1'b0; i_rows_m1 = '0; i_chunks_m1 = '0; i_res_ready = 1'b0;
        i_w_data = '0; i_x_data = '0; w_base = '0; w_inc = '0; x_el = '0;
        repeat (3) @(negedge i_clk);
        #1;
        n_cmp++; if ({o_busy, o_done, o_rd_en, o_res_valid} !== 4'b0) begin n_bad++; $display("FAIL reset_flags got %b want 0000", {o_busy, o_done, o_rd_en, o_res_valid}); end
        n_cmp++; if (o_w_addr !== 14'd0 || o_vp_a !== '0 || o_res_data !== 24'd0) begin n_bad++; $display("FAIL reset_data got addr %0d res %0d want 0", o_w_addr, o_res_data); end
        i_rst = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic test_basic_rows;
        w_base = 4'd1; w_inc = 4'd0; x_el = 4'd1;
        start_job(8'd2, 6'd3);
        collect(200, 0, -1);
        n_cmp++; if (got_data.size() !== 3) begin n_bad++; $display("FAIL basic_count got %0d want 3", got_data.size()); end
        for (int r = 0; r < 3; r++) if (r < got_data.size()) begin
            n_cmp++; if (got_data[r] !== 24'd256 || got_row[r] !== 8'(r)) begin n_bad++; $display("FAIL basic_row%0d got %0d@%0d want 256@%0d", r, $signed(got_data[r]), got_row[r], r); end
        end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL basic_done_count got %0d want 1", done_cnt); end
        n_cmp++; if (last_vld_cyc !== 14) begin n_bad++; $display("FAIL basic_latency got %0d want 14", last_vld_cyc); end
        n_cmp++; if (done_cyc !== 15) begin n_bad++; $display("FAIL basic_done_cycle got %0d want 15", done_cyc); end
        n_cmp++; if (rd_addr.size() !== 12) begin n_bad++; $display("FAIL basic_reads got %0d want 12", rd_addr.size()); end
    endtask

    task automatic test_negative;
        w_base = 4'h8; w_inc = 4'd0; x_el = 4'd7;
        start_job(8'd0, 6'd3);
        collect(100, 0, -1);
        n_cmp++; if (got_data.size() !== 1 || got_data[0] !== 24'(-14336) || got_row[0] !== 8'd0) begin n_bad++; $display("FAIL neg_result got n=%0d %0d want 1 -14336", got_data.size(), $signed(got_data[0])); end
        n_cmp++; if (got16.size() !== 1 || got16[0] !== 16'(-14336)) begin n_bad++; $display("FAIL neg_result16 got n=%0d %0d want 1 -14336", got16.size(), $signed(got16[0])); end
        n_cmp++; if (rd_addr.size() !== 4) begin n_bad++; $display("FAIL neg_reads got %0d want 4", rd_addr.size()); end
        for (int i = 0; i < 4; i++) if (i < rd_addr.size()) begin
            n_cmp++; if (rd_addr[i] !== 14'(i)) begin n_bad++; $display("FAIL neg_waddr%0d got %0d want %0d", i, rd_addr[i], i); end
        end
    endtask

    task automatic test_backpressure;
        w_base = 4'd1; w_inc = 4'd1; x_el = 4'd1;
        start_job(8'd5, 6'd0);
        collect(300, 20, -1);
        n_cmp++; if (rd_low !== 2) begin n_bad++; $display("FAIL bp_stall_reads got %0d want 2", rd_low); end
        n_cmp++; if (hold_vld !== 1'b1 || hold_data !== 24'd64 || hold_row !== 8'd0) begin n_bad++; $display("FAIL bp_hold got v%0d %0d@%0d want v1 64@0", hold_vld, hold_data, hold_row); end
        n_cmp++; if (got_data.size() !== 6) begin n_bad++; $display("FAIL bp_count got %0d want 6", got_data.size()); end
        for (int r = 0; r < 6; r++) if (r < got_data.size()) begin
            n_cmp++; if (got_data[r] !== 24'(64 * (r + 1)) || got_row[r] !== 8'(r)) begin n_bad++; $display("FAIL bp_row%0d got %0d@%0d want %0d@%0d", r, got_data[r], got_row[r], 64 * (r + 1), r); end
        end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL bp_done_count got %0d want 1", done_cnt); end
    endtask

    task automatic test_wrap;
        w_base = 4'h8; w_inc = 4'd0; x_el = 4'h8;
        start_job(8'd0, 6'd7);
        collect(100, 0, -1);
        n_cmp++; if (got16.size() !== 1 || got16[0] !== 16'h8000) begin n_bad++; $display("FAIL wrap16 got n=%0d %0d want 1 -32768", got16.size(), $signed(got16[0])); end
        n_cmp++; if (got_data.size() !== 1 || got_data[0] !== 24'd32768) begin n_bad++; $display("FAIL wrap24 got n=%0d %0d want 1 32768", got_data.size(), got_data[0]); end
    endtask

    task automatic test_reset_mid_job;
        int found, pre_done;
        found = 0; pre_done = 0;
        w_base = 4'd1; w_inc = 4'd0; x_el = 4'd1;
        start_job(8'd4, 6'd3);
        i_res_ready = 1'b1;
        for (int c = 0; c < 50 && found == 0; c++) begin
            #1;
            if (o_done) pre_done++;
            if (o_rd_en && o_w_addr == 14'd8) found = 1;
            else @(negedge i_clk);
        end
        n_cmp++; if (found !== 1) begin n_bad++; $display("FAIL rst_reach_row2 got %0d want 1", found); end
        i_rst = 1'b1;
        @(negedge i_clk);
        #1;
        n_cmp++; if ({o_busy, o_done, o_rd_en, o_res_valid} !== 4'b0 || pre_done !== 0) begin n_bad++; $display("FAIL rst_mid_flags got %b done%0d want 0000 done0", {o_busy, o_done, o_rd_en, o_res_valid}, pre_done); end
        n_cmp++; if (o_w_addr !== 14'd0 || o_vp_a !== '0 || o_res_data !== 24'd0) begin n_bad++; $display("FAIL rst_mid_data got addr %0d res %0d want 0", o_w_addr, o_res_data); end
        i_rst = 1'b0;
        @(negedge i_clk);
        w_base = 4'd2;
        start_job(8'd0, 6'd1);
        collect(100, 0, -1);
        n_cmp++; if (got_data.size() !== 1 || got_data[0] !== 24'd256 || got_row[0] !== 8'd0) begin n_bad++; $display("FAIL rst_new_job got n=%0d %0d@%0d want 1 256@0", got_data.size(), got_data[0], got_row[0]); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL rst_new_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_start_ignored;
        w_base = 4'd1; w_inc = 4'd0; x_el = 4'd3;
        start_job(8'd1, 6'd1);
        collect(100, 0, 2);
        n_cmp++; if (got_data.size() !== 2) begin n_bad++; $display("FAIL ign_count got %0d want 2", got_data.size()); end
        for (int r = 0; r < 2; r++) if (r < got_data.size()) begin
            n_cmp++; if (got_data[r] !== 24'd384 || got_row[r] !== 8'(r)) begin n_bad++; $display("FAIL ign_row%0d got %0d@%0d want 384@%0d", r, got_data[r], got_row[r], r); end
        end
        n_cmp++; if (rd_addr.size() !== 4) begin n_bad++; $display("FAIL ign_reads got %0d want 4", rd_addr.size()); end
        n_cmp++; if (done_cnt !== 1 || busy_end !== 0) begin n_bad++; $display("FAIL ign_done got %0d busy %0d want 1 busy 0", done_cnt, busy_end); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        @(negedge i_clk);
        test_reset();
        test_basic_rows();
        test_negative();
        test_backpressure();
        test_wrap();
        test_reset_mid_job();
        test_start_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
